// File: rtl/wb_burst_ram.sv
// Wishbone B4 registered-feedback RAM slave: classic cycles, linear and wrap-4/8/16
// incrementing bursts, byte-lane writes, and an error response for misaligned accesses.
module wb_burst_ram #(
    parameter int AW        = 10,
    parameter int INIT_ZERO = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);
    localparam int         DEPTH   = 1 << AW;
    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_END = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_SINGLE, ST_BURST, ST_ERR} state_t;

    state_t        r_state, w_state_next;
    logic          r_ack, r_err, w_ack_next, w_err_next;
    logic [AW-1:0] r_baddr, w_baddr_next, w_baddr_inc, w_wrap_mask, w_rd_addr, w_adr_word;
    logic [31:0]   r_dat, w_rd_word, w_mem_word;
    logic          w_req, w_load, w_adv, w_wr, w_rd_en, w_bypass;
    logic          w_unused_adr;

    // Power-up contents only; reset never touches the array.
    logic [31:0] r_mem [DEPTH] = '{default: (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx};

    genvar gi;

    assign w_req        = wb_cyc_i & wb_stb_i;
    assign w_adr_word   = wb_adr_i[AW+1:2];
    assign w_unused_adr = &{1'b0, wb_adr_i[31:AW+2]};

    always_comb begin
        unique case (wb_bte_i)
            2'b01:   w_wrap_mask = AW'(3);
            2'b10:   w_wrap_mask = AW'(7);
            2'b11:   w_wrap_mask = AW'(15);
            default: w_wrap_mask = '1;
        endcase
    end

    // Only the masked low bits advance; a linear burst masks every bit.
    assign w_baddr_inc  = r_baddr + AW'(1);
    assign w_baddr_next = (r_baddr & ~w_wrap_mask) | (w_baddr_inc & w_wrap_mask);

    always_comb begin
        w_state_next = r_state;
        w_ack_next   = 1'b0;
        w_err_next   = 1'b0;
        w_load       = 1'b0;
        w_adv        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (wb_adr_i[1:0] != 2'b00) begin
                        w_state_next = ST_ERR;
                        w_err_next   = 1'b1;
                    end else begin
                        w_state_next = (wb_cti_i == CTI_INC) ? ST_BURST : ST_SINGLE;
                        w_ack_next   = 1'b1;
                        w_load       = 1'b1;
                    end
                end
            end
            ST_SINGLE: w_state_next = ST_IDLE;
            ST_BURST: begin
                if (w_req && (wb_cti_i != CTI_END)) begin
                    w_ack_next = 1'b1;
                    w_adv      = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ERR:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ack is only high in SINGLE/BURST, so a write beat needs no state decode.
    assign w_wr      = r_ack & w_req & wb_we_i;
    assign w_rd_en   = w_load | w_adv;
    assign w_rd_addr = w_load ? w_adr_word : w_baddr_next;
    assign w_bypass  = w_wr && (w_rd_addr == r_baddr);

    assign w_mem_word = r_mem[w_rd_addr];

    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_rd_word[8*gi +: 8] = (w_bypass && wb_sel_i[gi]) ? wb_dat_i[8*gi +: 8]
                                                                      : w_mem_word[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
            r_baddr <= '0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_ack_next;
            r_err   <= w_err_next;
            if (w_load) begin
                r_baddr <= w_adr_word;
            end else if (w_adv) begin
                r_baddr <= w_baddr_next;
            end
            if (w_rd_en) begin
                r_dat <= w_rd_word;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_wr) begin
            for (int n = 0; n < 4; n++) begin
                if (wb_sel_i[n]) begin
                    r_mem[r_baddr][8*n +: 8] <= wb_dat_i[8*n +: 8];
                end
            end
        end
    end

    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_burst_ram.sv
// Bench for wb_burst_ram: a directed vector table, hand-written multi-cycle sequences and
// randomized classic/burst traffic checked against a word-array model of the RAM.
module tb_wb_burst_ram;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr, dat_w, dat_o;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack, err, rty;
    logic [2:0]  cti;
    logic [1:0]  bte;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vt [14];

    wb_burst_ram #(.AW(AW), .INIT_ZERO(1)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .wb_err_o(err), .wb_rty_o(rty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("ack_err_exclusive", 32'(ack & err), 32'h0);
        check("rty_zero", 32'(rty), 32'h0);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void mwrite(input int a, input logic [31:0] d, input logic [3:0] s);
        for (int n = 0; n < 4; n++)
            if (s[n]) mdl[a][8*n +: 8] = d[8*n +: 8];
    endfunction

    // Beat address in words, from the burst rules alone.
    function automatic int beat_addr(input int start, input int bt, input int i);
        int n;
        if (bt == 0) return (start + i) % DEPTH;
        n = 4 << (bt - 1);
        return start - (start % n) + ((start % n) + i) % n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
        sel = 4'h0; adr = 32'h0; dat_w = 32'h0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(ack || err) && n < 16);
    endtask

    task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp, output logic [31:0] rd);
        int n;
        adr = a; dat_w = d; sel = s; we = w; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
        wait_resp(n);
        check("classic_latency", 32'(n), 32'd1);
        resp = {ack, err};
        rd = dat_o;
        step();
        idle_bus();
        check("classic_resp_one_cycle", {30'b0, ack, err}, 32'h0);
        if (resp == 2'b10 && w) mwrite(int'(a[AW+1:2]), d, s);
    endtask

    // wr_mode: 0 read, 1 write, 2 random per beat. Stb drops for wait_len cycles before beat wait_at.
    task automatic burst(input int start, input int bt, input int len, input int wr_mode,
                         input bit rnd_data, input logic [31:0] dbase,
                         input int wait_at, input int wait_len);
        int n, a;
        logic w;
        logic [31:0] d;
        logic [3:0] s;
        for (int i = 0; i < len; i++) begin
            a = beat_addr(start, bt, i);
            w = (wr_mode == 2) ? 1'($urandom_range(0, 1)) : (wr_mode == 1);
            d = rnd_data ? 32'($urandom) : dbase + 32'(i);
            s = (wr_mode == 2) ? 4'($urandom_range(0, 15)) : 4'hF;
            if (i > 0 && i == wait_at) begin
                stb = 1'b0;
                for (int k = 0; k < wait_len; k++) begin
                    step();
                    check("burst_wait_ack_low", 32'(ack), 32'h0);
                end
            end
            adr = 32'(a) << 2; dat_w = d; sel = s; we = w;
            cti = (i == len - 1) ? 3'b111 : 3'b010; bte = 2'(bt); cyc = 1'b1; stb = 1'b1;
            if (i == 0 || i == wait_at) begin
                wait_resp(n);
                check("burst_first_latency", 32'(n), 32'd1);
            end else begin
                check("burst_ack_continuous", 32'(ack), 32'h1);
            end
            check("burst_err_low", 32'(err), 32'h0);
            if (!w) check($sformatf("burst_rd_w%0d", a), dat_o, mdl[a]);
            step();
            if (w) mwrite(a, d, s);
        end
        idle_bus();
        check("burst_end_ack_low", 32'(ack), 32'h0);
    endtask

    initial begin
        logic [1:0] resp;
        logic [31:0] rd, exp_rd;
        logic [3:0] pat;
        int n, word, bt, len, wat;
        logic mis, w;
        logic [31:0] a, d;
        logic [3:0] s;

        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        //        we    adr            dat            sel    err   chk   rd
        vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 32'h0000_0010, 32'h000000AA, 4'h1, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEAA};
        vt[4]  = '{1'b0, 32'h0000_0013, 32'h0,        4'hF, 1'b1, 1'b1, 32'hDEADBEAA};
        vt[5]  = '{1'b1, 32'h0000_0012, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'hDEADBEAA};
        vt[6]  = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEAA};
        vt[7]  = '{1'b1, 32'h0000_0014, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0, 32'h0};
        vt[8]  = '{1'b0, 32'h0000_0014, 32'h0,        4'hF, 1'b0, 1'b1, 32'h00000000};
        vt[9]  = '{1'b1, 32'h0000_0014, 32'hAABBCCDD, 4'h6, 1'b0, 1'b0, 32'h0};
        vt[10] = '{1'b0, 32'h0000_0014, 32'h0,        4'hF, 1'b0, 1'b1, 32'h00BBCC00};
        vt[11] = '{1'b1, 32'hFFFF_F018, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0};
        vt[12] = '{1'b0, 32'h0000_0018, 32'h0,        4'hF, 1'b0, 1'b1, 32'hCAFEF00D};
        vt[13] = '{1'b0, 32'h0000_0019, 32'h0,        4'hF, 1'b1, 1'b1, 32'hCAFEF00D};

        idle_bus();
        rst_n = 1'b0;
        step();
        step();
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_dat", dat_o, 32'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            classic(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, resp, rd);
            check($sformatf("vec%0d_resp", i), 32'(resp), vt[i].exp_err ? 32'h1 : 32'h2);
            if (vt[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
        end

        // Held request on a classic read: ack pattern 1,0,1,0 across four edges.
        pat = 4'b0101;
        adr = 32'h10; we = 1'b0; sel = 4'hF; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("held_req_ack%0d", i), 32'(ack), 32'(pat[i]));
            if (pat[i]) check("held_req_data", dat_o, 32'hDEADBEAA);
        end
        idle_bus();
        step();

        // Linear 4-beat read burst over preloaded words 8..11.
        for (int i = 0; i < 4; i++) classic(1'b1, 32'h20 + 32'(4 * i), 32'(i + 1), 4'hF, resp, rd);
        burst(8, 0, 4, 0, 1'b0, 32'h0, -1, 0);

        // Wrap-4 read from word 6, then wrap-4 write from word 6 and immediate reads.
        for (int i = 4; i < 8; i++) classic(1'b1, 32'(4 * i), 32'h400 + 32'(i), 4'hF, resp, rd);
        burst(6, 1, 4, 0, 1'b0, 32'h0, -1, 0);
        burst(6, 1, 4, 1, 1'b0, 32'hA0, -1, 0);
        classic(1'b0, 32'h1C, 32'h0, 4'hF, resp, rd);
        check("wrap_wr_then_rd_w7", rd, 32'hA1);
        classic(1'b0, 32'h10, 32'h0, 4'hF, resp, rd);
        check("wrap_wr_then_rd_w4", rd, 32'hA2);

        // Burst with a 2-cycle stb gap before beat 3.
        burst(100, 0, 6, 0, 1'b0, 32'h0, 3, 2);

        // Asynchronous reset during beat 2 of a burst.
        adr = 32'h20; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
        wait_resp(n);
        check("rst_burst_latency", 32'(n), 32'd1);
        check("rst_burst_beat1", dat_o, 32'h1);
        step();
        adr = 32'h24;
        check("rst_burst_beat2", dat_o, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", 32'(ack), 32'h0);
        check("rst_mid_err", 32'(err), 32'h0);
        check("rst_mid_dat", dat_o, 32'h0);
        idle_bus();
        step();
        step();
        rst_n = 1'b1;
        classic(1'b0, 32'h24, 32'h0, 4'hF, resp, rd);
        check("after_rst_resp", 32'(resp), 32'h2);
        check("after_rst_data", rd, 32'h2);

        // Randomized traffic against the word model.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                word = int'($urandom_range(0, 63));
                mis = ($urandom_range(0, 7) == 0);
                a = (32'($urandom) & 32'hFFFF_F000) | (32'(word) << 2)
                    | (mis ? 32'($urandom_range(1, 3)) : 32'h0);
                w = 1'($urandom_range(0, 1));
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                exp_rd = mdl[word];
                classic(w, a, d, s, resp, rd);
                check("rand_resp", 32'(resp), mis ? 32'h1 : 32'h2);
                if (!mis && !w) check("rand_rdata", rd, exp_rd);
            end else begin
                bt = int'($urandom_range(0, 3));
                len = int'($urandom_range(2, 12));
                wat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len - 1)) : -1;
                burst(int'($urandom_range(0, 63)), bt, len, 2, 1'b1, 32'h0, wat,
                      int'($urandom_range(1, 3)));
            end
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
